// File: rtl/ghostbus_host_bridge.sv
// ghostbus_host_bridge: valid/ready command stream to ghostbus master cycles.
// Supports single writes, single reads and auto-incrementing read bursts.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | cmd_ready high, waiting for a command
// WRITE   | gb_we pulse with latched address/data
// RD_WAIT | address on bus, waiting READ_DELAY edges for gb_din
// RESP    | response held on rsp_* until the consumer takes it
module ghostbus_host_bridge #(
  parameter int AW         = 12,
  parameter int DW         = 32,
  parameter int LW         = 8,
  parameter int READ_DELAY = 1
) (
  input  logic          gb_clk,
  input  logic          gb_rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  input  logic [LW-1:0] cmd_len,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_write,
  output logic [DW-1:0] rsp_rdata,
  output logic [AW-1:0] gb_addr,
  output logic [DW-1:0] gb_dout,
  output logic          gb_we,
  input  logic [DW-1:0] gb_din,
  output logic          busy
);

  // wait counter counts down from READ_DELAY to 0; capture happens on the 0 cycle
  localparam int WCW = (READ_DELAY < 1) ? 1 : $clog2(READ_DELAY + 1);

  typedef enum logic [1:0] {IDLE, WRITE, RD_WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    addr_d;
  logic [DW-1:0]    dout_d;
  logic             we_d;
  logic             rsp_valid_d;
  logic             rsp_write_d;
  logic [DW-1:0]    rsp_rdata_d;
  logic             cmd_ready_d;
  logic             busy_d;
  logic             write_q, write_d;
  logic [LW-1:0]    len_q, len_d;
  logic [LW-1:0]    beat_q, beat_d;
  logic [WCW-1:0]   wait_q, wait_d;

  // Next-state and next-output computation; every output is registered below.
  always_comb begin
    state_d     = state_q;
    addr_d      = gb_addr;
    dout_d      = gb_dout;
    we_d        = 1'b0;
    rsp_valid_d = rsp_valid;
    rsp_write_d = rsp_write;
    rsp_rdata_d = rsp_rdata;
    write_d     = write_q;
    len_d       = len_q;
    beat_d      = beat_q;
    wait_d      = wait_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          write_d = cmd_write;
          len_d   = cmd_len;
          beat_d  = '0;
          addr_d  = cmd_addr;
          if (cmd_write) begin
            dout_d  = cmd_wdata;
            we_d    = 1'b1;
            state_d = WRITE;
          end else begin
            wait_d  = WCW'(READ_DELAY);
            state_d = RD_WAIT;
          end
        end
      end
      WRITE: begin
        rsp_valid_d = 1'b1;
        rsp_write_d = 1'b1;
        rsp_rdata_d = '0;
        state_d     = RESP;
      end
      RD_WAIT: begin
        if (wait_q == '0) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = gb_din;
          state_d     = RESP;
        end else begin
          wait_d = wait_q - WCW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (write_q || (beat_q == len_q)) begin
            state_d = IDLE;
          end else begin
            addr_d  = gb_addr + AW'(1);
            beat_d  = beat_q + LW'(1);
            wait_d  = WCW'(READ_DELAY);
            state_d = RD_WAIT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // State register.
  always_ff @(posedge gb_clk or negedge gb_rst_n) begin
    if (!gb_rst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Bus, response and burst-tracking registers; reset clears everything so an abort drops pending work.
  always_ff @(posedge gb_clk or negedge gb_rst_n) begin
    if (!gb_rst_n) begin
      gb_addr   <= '0;
      gb_dout   <= '0;
      gb_we     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      write_q   <= 1'b0;
      len_q     <= '0;
      beat_q    <= '0;
      wait_q    <= '0;
    end else begin
      gb_addr   <= addr_d;
      gb_dout   <= dout_d;
      gb_we     <= we_d;
      rsp_valid <= rsp_valid_d;
      rsp_write <= rsp_write_d;
      rsp_rdata <= rsp_rdata_d;
      cmd_ready <= cmd_ready_d;
      busy      <= busy_d;
      write_q   <= write_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      wait_q    <= wait_d;
    end
  end

endmodule

// File: tb/tb_ghostbus_host_bridge.sv
// Bench for ghostbus_host_bridge: two instances (READ_DELAY 1 and 3), each
// driving its own decoder memory model with a matching read pipeline.
`timescale 1ns/1ps
module tb_ghostbus_host_bridge;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int LW = 8;

  logic          gb_clk = 1'b0;
  logic          gb_rst_n = 1'b0;
  logic          cmd_valid [2];
  logic          cmd_ready [2];
  logic          cmd_write [2];
  logic [AW-1:0] cmd_addr  [2];
  logic [DW-1:0] cmd_wdata [2];
  logic [LW-1:0] cmd_len   [2];
  logic          rsp_valid [2];
  logic          rsp_ready [2];
  logic          rsp_write [2];
  logic [DW-1:0] rsp_rdata [2];
  logic [AW-1:0] gb_addr   [2];
  logic [DW-1:0] gb_dout   [2];
  logic          gb_we     [2];
  logic [DW-1:0] gb_din    [2];
  logic          busy      [2];

  logic [DW-1:0] mem     [2][4096];
  logic [DW-1:0] ref_mem [2][4096];
  logic [DW-1:0] d1_p1, d1_p2;
  int            we_cnt [2];
  int            n_checks = 0;
  int            n_fail = 0;

  always #5 gb_clk = ~gb_clk;

  ghostbus_host_bridge #(.AW(AW), .DW(DW), .LW(LW), .READ_DELAY(1)) u_dut0 (
    .gb_clk(gb_clk), .gb_rst_n(gb_rst_n),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_write(cmd_write[0]),
    .cmd_addr(cmd_addr[0]), .cmd_wdata(cmd_wdata[0]), .cmd_len(cmd_len[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_write(rsp_write[0]),
    .rsp_rdata(rsp_rdata[0]), .gb_addr(gb_addr[0]), .gb_dout(gb_dout[0]),
    .gb_we(gb_we[0]), .gb_din(gb_din[0]), .busy(busy[0]));

  ghostbus_host_bridge #(.AW(AW), .DW(DW), .LW(LW), .READ_DELAY(3)) u_dut1 (
    .gb_clk(gb_clk), .gb_rst_n(gb_rst_n),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_write(cmd_write[1]),
    .cmd_addr(cmd_addr[1]), .cmd_wdata(cmd_wdata[1]), .cmd_len(cmd_len[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_write(rsp_write[1]),
    .rsp_rdata(rsp_rdata[1]), .gb_addr(gb_addr[1]), .gb_dout(gb_dout[1]),
    .gb_we(gb_we[1]), .gb_din(gb_din[1]), .busy(busy[1]));

  // Decoder models: registered read path delayed by READ_DELAY, write on gb_we, pulse counting.
  always @(posedge gb_clk) begin
    gb_din[0] <= mem[0][gb_addr[0]];
    d1_p1     <= mem[1][gb_addr[1]];
    d1_p2     <= d1_p1;
    gb_din[1] <= d1_p2;
    if (gb_we[0] === 1'b1) begin mem[0][gb_addr[0]] = gb_dout[0]; we_cnt[0] = we_cnt[0] + 1; end
    if (gb_we[1] === 1'b1) begin mem[1][gb_addr[1]] = gb_dout[1]; we_cnt[1] = we_cnt[1] + 1; end
  end

  // One command end to end on instance d, checked against the reference memory.
  task automatic run_cmd(input int d, input bit wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int len, input bit rnd);
    int cnt, nbeats, we0, rd, lat;
    bit hs;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    rd = (d == 0) ? 1 : 3;
    nbeats = wr ? 1 : len + 1;
    cnt = 0;
    while (cmd_ready[d] !== 1'b1 && cnt < 20) begin @(negedge gb_clk); cnt++; end
    n_checks++;
    if (cmd_ready[d] !== 1'b1) begin
      n_fail++; $display("FAIL accept_timeout dut%0d: cmd_ready=%b required 1", d, cmd_ready[d]);
      return;
    end
    we0 = we_cnt[d];
    cmd_valid[d] = 1'b1; cmd_write[d] = wr; cmd_addr[d] = addr;
    cmd_wdata[d] = wdata; cmd_len[d] = LW'(len);
    @(negedge gb_clk);
    cmd_valid[d] = 1'b0; cmd_write[d] = 1'($urandom); cmd_addr[d] = AW'($urandom);
    cmd_wdata[d] = $urandom; cmd_len[d] = LW'($urandom);
    if (wr) begin
      n_checks++;
      if ({gb_we[d], gb_addr[d], gb_dout[d]} !== {1'b1, addr, wdata}) begin
        n_fail++; $display("FAIL write_cycle dut%0d: we=%b addr=%h dout=%h required 1 %h %h",
                           d, gb_we[d], gb_addr[d], gb_dout[d], addr, wdata);
      end
    end
    for (int b = 0; b < nbeats; b++) begin
      ea = addr + AW'(b);
      ed = wr ? '0 : ref_mem[d][ea];
      lat = wr ? 2 : rd + 2;
      cnt = 1;
      while (rsp_valid[d] !== 1'b1 && cnt < 60) begin @(negedge gb_clk); cnt++; end
      n_checks++;
      if (cnt != lat) begin
        n_fail++; $display("FAIL rsp_latency dut%0d beat %0d: %0d cycles required %0d", d, b, cnt, lat);
        if (rsp_valid[d] !== 1'b1) return;
      end
      cnt = 0;
      hs = 1'b0;
      while (!hs && cnt < 60) begin
        rsp_ready[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        n_checks++;
        if ({rsp_valid[d], rsp_write[d], rsp_rdata[d], cmd_ready[d], gb_we[d]} !==
            {1'b1, wr, ed, 1'b0, 1'b0}) begin
          n_fail++; $display("FAIL rsp_beat dut%0d beat %0d: v=%b w=%b data=%h rdy=%b we=%b required 1 %b %h 0 0",
                             d, b, rsp_valid[d], rsp_write[d], rsp_rdata[d], cmd_ready[d], gb_we[d], wr, ed);
        end
        if (!wr) begin
          n_checks++;
          if (gb_addr[d] !== ea) begin
            n_fail++; $display("FAIL rd_addr dut%0d beat %0d: %h required %h", d, b, gb_addr[d], ea);
          end
        end
        hs = rsp_ready[d];
        @(negedge gb_clk);
        cnt++;
      end
    end
    rsp_ready[d] = 1'b1;
    n_checks++;
    if ({cmd_ready[d], busy[d], rsp_valid[d]} !== 3'b100) begin
      n_fail++; $display("FAIL idle_after dut%0d: ready=%b busy=%b valid=%b required 1 0 0",
                         d, cmd_ready[d], busy[d], rsp_valid[d]);
    end
    n_checks++;
    if (we_cnt[d] - we0 != (wr ? 1 : 0)) begin
      n_fail++; $display("FAIL we_pulses dut%0d: %0d required %0d", d, we_cnt[d] - we0, wr ? 1 : 0);
    end
    if (wr) ref_mem[d][addr] = wdata;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge gb_clk);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({gb_addr[d], gb_dout[d], gb_we[d], rsp_valid[d], rsp_write[d], rsp_rdata[d],
           cmd_ready[d], busy[d]} !== '0) begin
        n_fail++; $display("FAIL reset_outputs dut%0d: addr=%h dout=%h we=%b v=%b rdy=%b busy=%b required all 0",
                           d, gb_addr[d], gb_dout[d], gb_we[d], rsp_valid[d], cmd_ready[d], busy[d]);
      end
    end
    gb_rst_n = 1'b1;
    @(negedge gb_clk);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({cmd_ready[d], busy[d]} !== 2'b10) begin
        n_fail++; $display("FAIL ready_after_release dut%0d: ready=%b busy=%b required 1 0",
                           d, cmd_ready[d], busy[d]);
      end
    end
  endtask

  task automatic test_write_read();
    run_cmd(0, 1'b1, 12'h000, 32'h0000_0042, 0, 1'b0);
    run_cmd(0, 1'b0, 12'h000, 32'h0, 0, 1'b0);
    run_cmd(1, 1'b1, 12'h000, 32'h0000_0042, 0, 1'b0);
    run_cmd(1, 1'b0, 12'h000, 32'h0, 0, 1'b0);
  endtask

  task automatic test_burst();
    for (int i = 0; i < 8; i++) begin
      mem[0][12'h040 + i] = DW'(i);
      ref_mem[0][12'h040 + i] = DW'(i);
    end
    run_cmd(0, 1'b0, 12'h040, 32'h0, 7, 1'b0);
  endtask

  task automatic test_wrap_stall();
    run_cmd(0, 1'b0, 12'hFFE, 32'h0, 3, 1'b1);
    run_cmd(1, 1'b0, 12'hFFE, 32'h0, 3, 1'b1);
  endtask

  task automatic test_reset_abort();
    int we0;
    while (cmd_ready[0] !== 1'b1) @(negedge gb_clk);
    we0 = we_cnt[0];
    cmd_valid[0] = 1'b1; cmd_write[0] = 1'b0; cmd_addr[0] = 12'h200; cmd_len[0] = 8'd3;
    @(negedge gb_clk);
    cmd_valid[0] = 1'b0;
    #2 gb_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({gb_addr[0], gb_dout[0], gb_we[0], rsp_valid[0], rsp_write[0], rsp_rdata[0],
         cmd_ready[0], busy[0]} !== '0) begin
      n_fail++; $display("FAIL abort_outputs: addr=%h dout=%h we=%b v=%b rdy=%b busy=%b required all 0",
                         gb_addr[0], gb_dout[0], gb_we[0], rsp_valid[0], cmd_ready[0], busy[0]);
    end
    repeat (2) @(negedge gb_clk);
    gb_rst_n = 1'b1;
    @(negedge gb_clk);
    n_checks++;
    if ({cmd_ready[0], busy[0], rsp_valid[0]} !== 3'b100 || we_cnt[0] != we0) begin
      n_fail++; $display("FAIL abort_release: ready=%b busy=%b valid=%b we_pulses=%0d required 1 0 0 0",
                         cmd_ready[0], busy[0], rsp_valid[0], we_cnt[0] - we0);
    end
    run_cmd(0, 1'b1, 12'h201, 32'hCAFE_F00D, 0, 1'b0);
    run_cmd(0, 1'b0, 12'h200, 32'h0, 1, 1'b0);
  endtask

  task automatic test_read_delay3();
    for (int i = 0; i < 4; i++)
      run_cmd(1, 1'b1, AW'(12'h100 + i), 32'hA5A5_0000 + DW'(i * 17), 0, 1'b0);
    run_cmd(1, 1'b0, 12'h100, 32'h0, 3, 1'b0);
    run_cmd(1, 1'b0, 12'h101, 32'h0, 2, 1'b1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++)
      run_cmd(int'($urandom_range(0, 1)), 1'($urandom), AW'($urandom), $urandom,
              int'($urandom_range(0, 3)), 1'b1);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      cmd_valid[d] = 1'b0; cmd_write[d] = 1'b0; cmd_addr[d] = '0;
      cmd_wdata[d] = '0; cmd_len[d] = '0; rsp_ready[d] = 1'b1; we_cnt[d] = 0;
      for (int i = 0; i < 4096; i++) begin
        mem[d][i] = $urandom;
        ref_mem[d][i] = mem[d][i];
      end
    end
    test_reset();
    test_write_read();
    test_burst();
    test_wrap_stall();
    test_reset_abort();
    test_read_delay3();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
